// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access controller.
//
// Sits between the EX/MEM and MEM/WB pipeline registers. A load or store from
// EX/MEM is turned into a registered request/acknowledge transaction with a
// variable-latency data memory. Stall freezes the upstream pipeline until the
// access completes. A DONE cycle with Stall low lets MEM/WB capture readData
// before the next EX/MEM contents are looked at.
//
// Optional feature: define MEM_MISALIGN_CHECK_EN to add the misalign output and
// reject accesses whose byte address is not word aligned (no memory request).
//
// Ports:
//   CLK, RST_N           clock (rising edge), asynchronous active-low reset
//   MemRead, MemWrite    EX/MEM access request (both set = store)
//   ALUResult            byte address of the access
//   WriteData            store data
//   mem_req, mem_we      registered memory request / write enable
//   mem_addr, mem_wdata  registered address / store data, stable while mem_req
//   mem_ack, mem_rdata   single-cycle completion pulse / read data
//   readData             registered load result to MEM/WB
//   Stall                combinational pipeline freeze
//   bus_err              one-cycle pulse when an access times out
//   misalign             one-cycle pulse on a rejected unaligned access (optional)

module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] readData,
   output logic        Stall,
   output logic        bus_err
`ifdef MEM_MISALIGN_CHECK_EN
   ,
   output logic        misalign
`endif
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_e;

   // Last BUSY cycle index; BUSY lasts at most TIMEOUT_CYCLES cycles.
   localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic [31:0] read_data_q;
   logic        bus_err_q;
   logic [7:0]  cnt_q;

   logic        access;
   logic        misaligned;

   assign access = MemRead | MemWrite;

`ifdef MEM_MISALIGN_CHECK_EN
   logic misalign_q;
   assign misaligned = (ALUResult[1:0] != 2'b00);
   assign misalign   = misalign_q;
`else
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= StIdle;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         read_data_q <= 32'h0;
         bus_err_q   <= 1'b0;
         cnt_q       <= 8'h0;
`ifdef MEM_MISALIGN_CHECK_EN
         misalign_q  <= 1'b0;
`endif
      end else begin
         // Status pulses only live for the single DONE cycle.
         bus_err_q <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
         case (state_q)
            StIdle: begin
               // mem_ack is deliberately ignored here.
               if (access) begin
                  if (misaligned) begin
`ifdef MEM_MISALIGN_CHECK_EN
                     misalign_q <= 1'b1;
`endif
                     state_q <= StDone;
                  end else begin
                     mem_addr_q  <= ALUResult;
                     mem_wdata_q <= WriteData;
                     mem_we_q    <= MemWrite;  // read+write together is a store
                     mem_req_q   <= 1'b1;
                     cnt_q       <= 8'h0;
                     state_q     <= StBusy;
                  end
               end
            end
            StBusy: begin
               if (mem_ack) begin
                  if (!mem_we_q) begin
                     read_data_q <= mem_rdata;
                  end
                  mem_req_q <= 1'b0;
                  cnt_q     <= 8'h0;
                  state_q   <= StDone;
               end else if (cnt_q == CntLast) begin
                  if (!mem_we_q) begin
                     read_data_q <= ERR_DATA;
                  end
                  mem_req_q <= 1'b0;
                  cnt_q     <= 8'h0;
                  bus_err_q <= 1'b1;
                  state_q   <= StDone;
               end else begin
                  cnt_q <= cnt_q + 8'h1;
               end
            end
            StDone: begin
               // One unstalled cycle so the served instruction leaves EX/MEM
               // before its request signals could be seen again.
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Stall is forced low while reset is held so the pipeline is not frozen.
   always_comb begin
      Stall = 1'b0;
      if (RST_N) begin
         case (state_q)
            StIdle:  Stall = access;
            StBusy:  Stall = 1'b1;
            default: Stall = 1'b0;
         endcase
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign readData  = read_data_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   localparam int unsigned TO = 8;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] ALUResult = 32'h0;
   logic [31:0] WriteData = 32'h0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] readData;
   logic        Stall;
   logic        bus_err;
`ifdef MEM_MISALIGN_CHECK_EN
   logic        misalign;
`endif

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_rd = 32'h0;

   mem_access_unit #(
      .TIMEOUT_CYCLES(TO),
      .ERR_DATA      (32'hDEADBEEF)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .ALUResult(ALUResult),
      .WriteData(WriteData),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .readData (readData),
      .Stall    (Stall),
      .bus_err  (bus_err)
`ifdef MEM_MISALIGN_CHECK_EN
      ,
      .misalign (misalign)
`endif
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Drives one access, acts as the memory (ack in BUSY cycle ack_at, 0 = never),
   // and compares against the expected readData pushed at issue time.
   task automatic run_access(input string name, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int ack_at, input logic [31:0] rdata,
                             input logic exp_err, input logic exp_mis, input int exp_busy,
                             output int req_cyc, output int done_cyc);
      int stall_n = 0;
      int req_n = 0;
      int n = 0;
      bit done = 0;
      logic [31:0] exp_rd;
      req_cyc = -1;
      done_cyc = -1;
      @(negedge CLK);
      MemRead = rd;
      MemWrite = wr;
      ALUResult = addr;
      WriteData = wdata;
      mem_ack = 1'b0;
      if (rd && !wr && !exp_mis) exp_rd = exp_err ? 32'hDEADBEEF : rdata;
      else exp_rd = last_rd;
      exp_q.push_back(exp_rd);
      while (!done && n < 64) begin
         #1;
         if (Stall) stall_n++;
         if (mem_req) begin
            if (req_n == 0) req_cyc = cyc;
            req_n++;
            total++;
            if (mem_addr !== addr || mem_wdata !== wdata || mem_we !== wr) begin
               bad++;
               $display("FAIL %s req_fields: addr=%h wdata=%h we=%b required addr=%h wdata=%h we=%b",
                        name, mem_addr, mem_wdata, mem_we, addr, wdata, wr);
            end
            mem_ack = (req_n == ack_at);
            mem_rdata = (req_n == ack_at) ? rdata : 32'h5A5A_5A5A;
         end else begin
            mem_ack = 1'b0;
         end
         if (n > 0 && !Stall) begin
            done = 1;
            done_cyc = cyc;
            exp_rd = exp_q.pop_front();
            total++;
            if (readData !== exp_rd) begin
               bad++;
               $display("FAIL %s readData: got %h required %h", name, readData, exp_rd);
            end
            total++;
            if (bus_err !== exp_err) begin
               bad++;
               $display("FAIL %s bus_err_done: got %b required %b", name, bus_err, exp_err);
            end
`ifdef MEM_MISALIGN_CHECK_EN
            total++;
            if (misalign !== exp_mis) begin
               bad++;
               $display("FAIL %s misalign: got %b required %b", name, misalign, exp_mis);
            end
`endif
            last_rd = exp_rd;
            MemRead = 1'b0;
            MemWrite = 1'b0;
         end else begin
            total++;
            if (bus_err !== 1'b0) begin
               bad++;
               $display("FAIL %s bus_err_early: got %b required 0", name, bus_err);
            end
         end
         n++;
         if (!done) @(negedge CLK);
      end
      mem_ack = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s completion: got no DONE within 64 cycles required DONE", name);
         MemRead = 1'b0;
         MemWrite = 1'b0;
      end
      total++;
      if (stall_n != exp_busy + 1) begin
         bad++;
         $display("FAIL %s stall_len: got %0d required %0d", name, stall_n, exp_busy + 1);
      end
      total++;
      if (req_n != exp_busy) begin
         bad++;
         $display("FAIL %s req_len: got %0d required %0d", name, req_n, exp_busy);
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      #12;
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, readData, bus_err, Stall} !== '0) begin
         bad++;
         $display("FAIL reset_values: got req=%b we=%b addr=%h wdata=%h rd=%h err=%b stall=%b required all 0",
                  mem_req, mem_we, mem_addr, mem_wdata, readData, bus_err, Stall);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      last_rd = 32'h0;
   endtask

   task automatic test_load_zero_wait();
      int rc, dc;
      run_access("load_zero_wait", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'h1234_5678,
                 1'b0, 1'b0, 1, rc, dc);
   endtask

   task automatic test_store_wait();
      int rc, dc;
      run_access("store_wait4", 1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4, 32'h1111_2222,
                 1'b0, 1'b0, 4, rc, dc);
   endtask

   task automatic test_timeout();
      int rc, dc;
      run_access("timeout", 1'b1, 1'b0, 32'h0000_0030, 32'h0, 0, 32'h0, 1'b1, 1'b0, TO, rc, dc);
   endtask

   task automatic test_read_write_both();
      int rc, dc;
      run_access("rd_and_wr", 1'b1, 1'b1, 32'h0000_0044, 32'h0BEE_F00D, 2, 32'h3333_4444,
                 1'b0, 1'b0, 2, rc, dc);
   endtask

   task automatic test_idle_ack();
      @(negedge CLK);
      mem_ack = 1'b1;
      mem_rdata = 32'h0BAD_0BAD;
      #1;
      total++;
      if (Stall !== 1'b0) begin
         bad++;
         $display("FAIL idle_ack_stall: got %b required 0", Stall);
      end
      @(negedge CLK);
      mem_ack = 1'b0;
      #1;
      total++;
      if (mem_req !== 1'b0 || readData !== last_rd || bus_err !== 1'b0) begin
         bad++;
         $display("FAIL idle_ack_ignored: got req=%b rd=%h err=%b required req=0 rd=%h err=0",
                  mem_req, readData, bus_err, last_rd);
      end
   endtask

   task automatic test_back_to_back();
      int rc1, dc1, rc2, dc2;
      run_access("b2b_first", 1'b1, 1'b0, 32'h0000_0050, 32'h0, 1, 32'hA5A5_0001,
                 1'b0, 1'b0, 1, rc1, dc1);
      run_access("b2b_second", 1'b1, 1'b0, 32'h0000_0054, 32'h0, 3, 32'hA5A5_0002,
                 1'b0, 1'b0, 3, rc2, dc2);
      // DONE cycle, then one IDLE cycle, then BUSY with mem_req high.
      total++;
      if (rc2 - dc1 != 2) begin
         bad++;
         $display("FAIL b2b_gap: got %0d cycles from DONE to req required 2", rc2 - dc1);
      end
   endtask

   task automatic test_misalign();
      int rc, dc;
`ifdef MEM_MISALIGN_CHECK_EN
      run_access("misalign", 1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0, 1'b0, 1'b1, 0, rc, dc);
`else
      run_access("unaligned_load", 1'b1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'h7766_5544,
                 1'b0, 1'b0, 1, rc, dc);
`endif
   endtask

   task automatic test_reset_mid_busy();
      int rc, dc;
      @(negedge CLK);
      MemRead = 1'b1;
      ALUResult = 32'h0000_0040;
      mem_ack = 1'b0;
      repeat (3) @(negedge CLK);
      #2;
      total++;
      if (mem_req !== 1'b1) begin
         bad++;
         $display("FAIL mid_busy_pre: got req=%b required 1", mem_req);
      end
      RST_N = 1'b0;
      #1;
      total++;
      if (mem_req !== 1'b0 || Stall !== 1'b0 || readData !== 32'h0) begin
         bad++;
         $display("FAIL mid_busy_reset: got req=%b stall=%b rd=%h required 0 0 00000000",
                  mem_req, Stall, readData);
      end
      MemRead = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      last_rd = 32'h0;
      @(negedge CLK);
      #1;
      total++;
      if (mem_req !== 1'b0 || Stall !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle: got req=%b stall=%b required 0 0", mem_req, Stall);
      end
      run_access("post_reset_load", 1'b1, 1'b0, 32'h0000_0060, 32'h0, 2, 32'hFEED_0001,
                 1'b0, 1'b0, 2, rc, dc);
   endtask

   initial begin
      test_reset();
      test_load_zero_wait();
      test_store_wait();
      test_timeout();
      test_read_write_both();
      test_idle_ack();
      test_back_to_back();
      test_misalign();
      test_reset_mid_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
